// File: rtl/cmpl_arbiter_pkg.sv
// Shared completion-port types for the ROB completion arbiter.
// ROB_SZ and XLEN come from the build; fallback values apply when they are not supplied.
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package cmpl_arbiter_pkg;

  localparam int ROB_SZ_P = `ROB_SZ;
  localparam int XLEN_P   = `XLEN;
  localparam int IDX_W    = $clog2(ROB_SZ_P);
  localparam int STAT_W   = 16;

  // Field set mirrors the ROB completion packet (IC_ROB_PACKET).
  typedef struct packed {
    logic [IDX_W-1:0]  rob_idx;
    logic [XLEN_P-1:0] result;
    logic [XLEN_P-1:0] rs2_value;
    logic              take_branch;
  } CMPL_REQ;

endpackage

// File: rtl/cmpl_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first request at or after rr_ptr,
// and the pointer moves to the slot just past the winner.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_idx;
  logic          found;
  int            j;

  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int off = 0; off < N; off++) begin
      j = (int'(rr_ptr) + off) % N;
      if (!found && req[j]) begin
        gnt[j]  = 1'b1;
        win_idx = PW'(j);
        found   = 1'b1;
      end
    end
  end

  // Pointer holds when idle so an idle cycle does not skip anyone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= PW'((int'(win_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/cmpl_arbiter.sv
// Shares the single ROB completion port between N_REQ FUs via 1-entry holding buffers
// and a round-robin arbiter. Define CMPL_ARB_STATS_EN to add grant/conflict counters.
module cmpl_arbiter
  import cmpl_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ROB_SZ = `ROB_SZ,
  parameter int XLEN   = `XLEN
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                fu_valid,
  output logic [N_REQ-1:0]                fu_ready,
  input  logic [N_REQ*$clog2(ROB_SZ)-1:0] fu_rob_idx,
  input  logic [N_REQ*XLEN-1:0]           fu_result,
  input  logic [N_REQ*XLEN-1:0]           fu_rs2_value,
  input  logic [N_REQ-1:0]                fu_take_branch,
  output logic                            complete_en,
  output logic [$clog2(ROB_SZ)-1:0]       complete_idx,
  output logic [XLEN-1:0]                 complete_result,
  output logic [XLEN-1:0]                 complete_rs2_value,
  output logic                            complete_take_br
`ifdef CMPL_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]         stat_grants,
  output logic [STAT_W-1:0]               stat_conflicts
`endif
);

  localparam int IW = $clog2(ROB_SZ);

  CMPL_REQ            fu_req   [N_REQ];
  CMPL_REQ            buf_q_p0 [N_REQ];
  logic [N_REQ-1:0]   buf_v_p0;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   accept;
  CMPL_REQ            win_p0;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      fu_req[i].rob_idx     = fu_rob_idx[i*IW +: IW];
      fu_req[i].result      = fu_result[i*XLEN +: XLEN];
      fu_req[i].rs2_value   = fu_rs2_value[i*XLEN +: XLEN];
      fu_req[i].take_branch = fu_take_branch[i];
    end
  end

  // A granted slot may be refilled on the same edge it drains.
  assign fu_ready = ~buf_v_p0 | grant;
  assign accept   = fu_valid & fu_ready;

  // ---- stage p0: per-FU holding buffers ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_v_p0 <= '0;
    end else begin
      buf_v_p0 <= accept | (buf_v_p0 & ~grant);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        buf_q_p0[i] <= fu_req[i];
      end
    end
  end

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clock (clock),
    .reset (reset),
    .req   (buf_v_p0),
    .gnt   (grant)
  );

  always_comb begin
    win_p0 = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_p0 = buf_q_p0[i];
      end
    end
  end

  // ---- stage p1: registered ROB completion port ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      complete_en        <= 1'b0;
      complete_idx       <= '0;
      complete_result    <= '0;
      complete_rs2_value <= '0;
      complete_take_br   <= 1'b0;
    end else begin
      complete_en <= |grant;
      if (|grant) begin
        complete_idx       <= IW'(win_p0.rob_idx);
        complete_result    <= XLEN'(win_p0.result);
        complete_rs2_value <= XLEN'(win_p0.rs2_value);
        complete_take_br   <= win_p0.take_branch;
      end
    end
  end

`ifdef CMPL_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [STAT_W-1:0] grant_cnt [N_REQ];
  logic [STAT_W-1:0] conflict_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        grant_cnt[i] <= '0;
      end
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant[i]) begin
          grant_cnt[i] <= sat_inc(grant_cnt[i]);
        end
      end
      if ($countones(buf_v_p0) > 1) begin
        conflict_cnt <= sat_inc(conflict_cnt);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      stat_grants[i*STAT_W +: STAT_W] = grant_cnt[i];
    end
  end
  assign stat_conflicts = conflict_cnt;
`endif

endmodule
